// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART receive frame controller.
package uart_frame_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR    = 3'd1,
    LEN     = 3'd2,
    PAYLOAD = 3'd3,
    CSUM    = 3'd4,
    WRITE   = 3'd5
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_CSUM    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_req_t;

endpackage

// File: rtl/uart_rx_frame_ctrl_if.sv
// Byte stream in from the UART receiver, register-write burst and status out.
interface uart_rx_frame_ctrl_if;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic       frame_done;
  logic       frame_err;
  logic [1:0] err_code;

  modport master (
    output rx_byte, rx_valid,
    input  wr_en, wr_addr, wr_data, busy, frame_done, frame_err, err_code
  );

  modport slave (
    input  rx_byte, rx_valid,
    output wr_en, wr_addr, wr_data, busy, frame_done, frame_err, err_code
  );
endinterface

// File: rtl/uart_frame_buf.sv
// Payload register file: one synchronous write port, one combinational read port.
module uart_frame_buf #(
  parameter int MAX_LEN = 16,
  parameter int IDX_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] widx,
  input  logic [7:0]       wdata,
  input  logic [IDX_W-1:0] ridx,
  output logic [7:0]       rdata
);

  logic [MAX_LEN-1:0][7:0] mem;

  always_ff @(posedge clk)
    if (we) mem[widx] <= wdata;

  assign rdata = mem[ridx];

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Frame controller: sync hunt, header/payload capture, checksum gate, write burst.
module uart_rx_frame_ctrl
  import uart_frame_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE    = uart_frame_pkg::SYNC_BYTE_DEF,
  parameter int         MAX_LEN      = 16,
  parameter int         TIMEOUT_CLKS = 21700
) (
  input  logic           clk,
  input  logic           rst,
  uart_rx_frame_ctrl_if.slave bus
);

  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TMO_W = $clog2(TIMEOUT_CLKS);
  localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);
  // Error fires on the edge where the counter would reach TIMEOUT_CLKS-1.
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CLKS - 2);

  state_t           state_q, state_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       len_q, len_d;
  logic [7:0]       idx_q, idx_d;
  logic [7:0]       csum_q, csum_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  wr_req_t          wr_q, wr_d;
  logic             wr_en_q, wr_en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [1:0]       code_q, code_d;

  logic             tmo_act, tmo_hit;
  logic [7:0]       sum_b;
  logic             buf_we;
  logic [IDX_W-1:0] rd_idx;
  logic [7:0]       rd_data;

  uart_frame_buf #(.MAX_LEN(MAX_LEN), .IDX_W(IDX_W)) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .widx  (idx_q[IDX_W-1:0]),
    .wdata (bus.rx_byte),
    .ridx  (rd_idx),
    .rdata (rd_data)
  );

  assign tmo_act = state_q inside {ADDR, LEN, PAYLOAD, CSUM};
  assign tmo_hit = tmo_act && !bus.rx_valid && (tmo_q == TMO_LAST);
  assign sum_b   = csum_q + bus.rx_byte;
  // In CSUM the index holds the payload count; the burst always starts at slot 0.
  assign rd_idx  = (state_q == WRITE) ? idx_q[IDX_W-1:0] : '0;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    idx_d   = idx_q;
    csum_d  = csum_q;
    wr_d    = wr_q;
    wr_en_d = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    code_d  = code_q;
    buf_we  = 1'b0;
    case (state_q)
      IDLE:
        if (bus.rx_valid && bus.rx_byte == SYNC_BYTE) begin
          state_d = ADDR;
          csum_d  = '0;
          idx_d   = '0;
        end
      ADDR:
        if (bus.rx_valid) begin
          addr_d  = bus.rx_byte;
          csum_d  = sum_b;
          state_d = LEN;
        end
      LEN:
        if (bus.rx_valid) begin
          len_d  = bus.rx_byte;
          csum_d = sum_b;
          idx_d  = '0;
          if (bus.rx_byte > MAX_LEN_B) begin
            err_d   = 1'b1;
            code_d  = ERR_LEN;
            state_d = IDLE;
          end else if (bus.rx_byte == 8'd0) begin
            state_d = CSUM;
          end else begin
            state_d = PAYLOAD;
          end
        end
      PAYLOAD:
        if (bus.rx_valid) begin
          buf_we = 1'b1;
          csum_d = sum_b;
          idx_d  = idx_q + 8'd1;
          if (idx_q + 8'd1 == len_q) state_d = CSUM;
        end
      CSUM:
        if (bus.rx_valid) begin
          if (sum_b != 8'd0) begin
            err_d   = 1'b1;
            code_d  = ERR_CSUM;
            state_d = IDLE;
          end else if (len_q == 8'd0) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            wr_en_d = 1'b1;
            wr_d    = '{addr: addr_q, data: rd_data};
            idx_d   = 8'd1;
            state_d = WRITE;
          end
        end
      WRITE:
        if (idx_q == len_q) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          wr_en_d = 1'b1;
          wr_d    = '{addr: addr_q + idx_q, data: rd_data};
          idx_d   = idx_q + 8'd1;
        end
      default: state_d = IDLE;
    endcase
    if (tmo_hit) begin
      err_d   = 1'b1;
      code_d  = ERR_TIMEOUT;
      state_d = IDLE;
    end
    busy_d = (state_d != IDLE);
    tmo_d  = (!tmo_act || bus.rx_valid || state_d != state_q) ? '0 : tmo_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      csum_q  <= '0;
      tmo_q   <= '0;
      wr_q    <= '0;
      wr_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      csum_q  <= csum_d;
      tmo_q   <= tmo_d;
      wr_q    <= wr_d;
      wr_en_q <= wr_en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end

  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_q.addr;
  assign bus.wr_data    = wr_q.data;
  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;
  assign bus.frame_err  = err_q;
  assign bus.err_code   = code_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed plus randomized frames checked against a frame-level reference model.
module tb_uart_rx_frame_ctrl;

  localparam int MAX_LEN = 16;
  localparam int T       = 21700;

  typedef logic [7:0] bq_t[$];
  typedef struct {int c; logic [7:0] a; logic [7:0] d;} wr_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_rx_frame_ctrl_if bus();

  uart_rx_frame_ctrl #(.SYNC_BYTE(8'hA5), .MAX_LEN(MAX_LEN), .TIMEOUT_CLKS(T)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  wr_t wq[$];
  int  dq[$];
  int  eq[$];
  int  ecq[$];
  int  viol = 0;
  int  tests = 0, fails = 0;

  always @(negedge clk)
    if (rst === 1'b0) begin
      if (bus.wr_en) wq.push_back('{cyc, bus.wr_addr, bus.wr_data});
      if (bus.frame_done) dq.push_back(cyc);
      if (bus.frame_err) begin eq.push_back(cyc); ecq.push_back(int'(bus.err_code)); end
      if (bus.frame_done && bus.frame_err) viol++;
      if (bus.wr_en && !bus.busy) viol++;
      if (bus.frame_done && bus.busy) viol++;
      if (bus.frame_err && bus.busy) viol++;
    end

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int head(input int q[$]);
    return (q.size() > 0) ? q[0] : -99999;
  endfunction

  task automatic clear_ev();
    wq.delete(); dq.delete(); eq.delete(); ecq.delete();
  endtask

  task automatic send(input logic [7:0] b, input int gap, output int c);
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_byte  = b;
    c = cyc;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.rx_byte  = 8'($urandom);
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_ev(input int budget);
    int n = 0;
    while (dq.size() + eq.size() == 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
  endtask

  // Model: frame outcome depends only on len vs MAX_LEN and the byte sum mod 256.
  task automatic run_frame(input bq_t f, input string tag);
    int c, n, len, s, exp_done;
    int bc[$];
    clear_ev();
    send(8'hA5, $urandom_range(0, 2), c);
    chk({tag, "/busy_rise"}, int'(bus.busy), 1);
    foreach (f[i]) begin
      send(f[i], $urandom_range(0, 2), c);
      bc.push_back(c);
    end
    wait_ev(60);
    len = int'(f[1]);
    n   = bc[bc.size()-1];
    if (len > MAX_LEN) begin
      chk({tag, "/len_err_cnt"}, eq.size(), 1);
      chk({tag, "/len_err_cyc"}, head(eq) - bc[1], 1);
      chk({tag, "/len_err_code"}, head(ecq), 1);
      chk({tag, "/len_no_done"}, dq.size(), 0);
      chk({tag, "/len_no_wr"}, wq.size(), 0);
      for (int k = 0; k < 3; k++) send(8'($urandom_range(0, 8'hA4)), 0, c);
      repeat (3) @(negedge clk);
      chk({tag, "/after_len_ignored"}, eq.size() + dq.size() + wq.size(), 1);
    end else begin
      s = 0;
      foreach (f[i]) s += int'(f[i]);
      exp_done = (s % 256 == 0) ? 1 : 0;
      chk({tag, "/done_cnt"}, dq.size(), exp_done);
      chk({tag, "/err_cnt"}, eq.size(), 1 - exp_done);
      if (exp_done == 1) begin
        chk({tag, "/done_cyc"}, head(dq) - n, len + 1);
        chk({tag, "/wr_cnt"}, wq.size(), len);
        foreach (wq[i])
          if (i < len) begin
            chk({tag, "/wr_addr"}, int'(wq[i].a), (int'(f[0]) + i) % 256);
            chk({tag, "/wr_data"}, int'(wq[i].d), int'(f[2+i]));
            chk({tag, "/wr_cyc"}, wq[i].c - n, 1 + i);
          end
      end else begin
        chk({tag, "/csum_code"}, head(ecq), 2);
        chk({tag, "/csum_cyc"}, head(eq) - n, 1);
        chk({tag, "/csum_no_wr"}, wq.size(), 0);
        chk({tag, "/code_hold"}, int'(bus.err_code), 2);
      end
    end
    chk({tag, "/busy_end"}, int'(bus.busy), 0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t fr;
    int c, len, sum, mode;
    logic [7:0] addr, b;

    rst = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_byte  = 8'h00;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst/wr_en", int'(bus.wr_en), 0);
    chk("rst/wr_addr", int'(bus.wr_addr), 0);
    chk("rst/wr_data", int'(bus.wr_data), 0);
    chk("rst/busy", int'(bus.busy), 0);
    chk("rst/frame_done", int'(bus.frame_done), 0);
    chk("rst/frame_err", int'(bus.frame_err), 0);
    chk("rst/err_code", int'(bus.err_code), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Garbage before sync must be silent.
    clear_ev();
    send(8'h00, 1, c);
    send(8'hFF, 1, c);
    repeat (3) @(negedge clk);
    chk("garbage/events", eq.size() + dq.size() + wq.size(), 0);
    chk("garbage/busy", int'(bus.busy), 0);

    fr = {8'h10, 8'h02, 8'h11, 8'h22, 8'hBB}; run_frame(fr, "good");
    fr = {8'h10, 8'h02, 8'h11, 8'h22, 8'hBC}; run_frame(fr, "badcsum");
    fr = {8'h10, 8'h20};                      run_frame(fr, "oversize");
    fr = {8'hFF, 8'h02, 8'hAA, 8'hBB, 8'h9A}; run_frame(fr, "wrap");

    // Timeout after the address byte.
    clear_ev();
    send(8'hA5, 0, c);
    send(8'h10, 0, c);
    wait_ev(T + 100);
    chk("tmo_addr/err_cnt", eq.size(), 1);
    chk("tmo_addr/err_cyc", head(eq) - c, T);
    chk("tmo_addr/code", head(ecq), 3);
    chk("tmo_addr/no_done", dq.size(), 0);

    fr = {8'h33, 8'h00, 8'hCD}; run_frame(fr, "len0");

    // Timeout inside the payload.
    clear_ev();
    send(8'hA5, 0, c);
    send(8'h20, 1, c);
    send(8'h03, 0, c);
    send(8'h01, 2, c);
    wait_ev(T + 100);
    chk("tmo_pay/err_cyc", head(eq) - c, T);
    chk("tmo_pay/code", head(ecq), 3);
    chk("tmo_pay/no_wr", wq.size(), 0);

    // Reset in the middle of a payload.
    clear_ev();
    send(8'hA5, 0, c);
    send(8'h10, 0, c);
    send(8'h04, 0, c);
    send(8'h11, 0, c);
    send(8'h22, 0, c);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst/busy", int'(bus.busy), 0);
    chk("midrst/wr_en", int'(bus.wr_en), 0);
    chk("midrst/wr_addr", int'(bus.wr_addr), 0);
    chk("midrst/wr_data", int'(bus.wr_data), 0);
    chk("midrst/err_code", int'(bus.err_code), 0);
    chk("midrst/done_err", int'(bus.frame_done) + int'(bus.frame_err), 0);
    @(negedge clk);
    rst = 1'b0;
    fr = {8'h40, 8'h03, 8'h01, 8'h02, 8'h03, 8'hB6}; run_frame(fr, "postrst");

    for (int k = 0; k < 25; k++) begin
      fr.delete();
      addr = 8'($urandom);
      mode = $urandom_range(0, 7);
      len  = (mode == 0) ? $urandom_range(MAX_LEN + 1, 255) : $urandom_range(0, MAX_LEN);
      fr.push_back(addr);
      fr.push_back(8'(len));
      if (len <= MAX_LEN) begin
        sum = int'(addr) + len;
        for (int i = 0; i < len; i++) begin
          b = ($urandom_range(0, 3) == 0) ? 8'hA5 : 8'($urandom);
          fr.push_back(b);
          sum += int'(b);
        end
        b = 8'(0 - sum);
        if (mode == 1) b = b + 8'($urandom_range(1, 255));
        fr.push_back(b);
      end
      run_frame(fr, $sformatf("rand%0d", k));
    end

    chk("invariants", viol, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
